// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with a small prefetch queue
//
// Issues one word-address fetch at a time to instruction memory and keeps
// returned words, tagged with their word address, in a DEPTH-entry queue.
// A redirect flushes the queue and restarts fetching at redirect_pc; a
// response still in flight at that moment is absorbed in the DROP state.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_req, imem_addr         fetch request and its word address
//   imem_gnt                    memory accepted the request this cycle
//   imem_rvalid, imem_rdata     response for the outstanding request
//   redirect, redirect_pc       flush and refetch from a new word address
//   inst_valid, inst, inst_pc   queue head (instruction and its word address)
//   inst_ready                  consumer takes the head when inst_valid is high
//   count                       number of queued entries, 0..DEPTH
module ifetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-3:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-3:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-3:0]            redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [XLEN-3:0]            inst_pc,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = XLEN - 2;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t        state;
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] pend_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   q_inst [DEPTH];
    logic [AW-1:0] q_pc   [DEPTH];

    logic          pop;
    logic          push;
    logic [CW-1:0] count_next;
    logic          slot_free;

    assign imem_req   = (state == REQ);
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

    assign pop  = inst_valid && inst_ready;
    assign push = (state == WAIT) && imem_rvalid;

    // Occupancy after this cycle's push and pop. A new request is only
    // issued when this leaves a free slot, so the response for it can
    // always be pushed without overflowing.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        slot_free = (count_next < CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
        end else if (redirect) begin
            // Flush wins over push/pop; a same-cycle pop is killed.
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= redirect_pc;
            case (state)
                IDLE:    state <= IDLE;
                REQ:     state <= imem_gnt ? DROP : IDLE;
                WAIT:    state <= imem_rvalid ? IDLE : DROP;
                // The one outstanding response is consumed either way.
                default: state <= imem_rvalid ? IDLE : DROP;
            endcase
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case (state)
                IDLE: begin
                    if (slot_free) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        pend_pc  <= fetch_pc;
                        fetch_pc <= fetch_pc + AW'(1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= slot_free ? REQ : IDLE;
                    end
                end
                default: begin
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Queue storage needs no reset: entries are only read when counted.
    always_ff @(posedge clk) begin
        if (!reset && !redirect && push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= pend_pc;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch with a randomized memory
module tb_ifetch;

    localparam int              XLEN     = 32;
    localparam int              DEPTH    = 4;
    localparam int              AW       = XLEN - 2;
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]   RESET_PC = '0;

    logic          clk;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic [CW-1:0] count;

    ifetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   word;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;

    // memory model state
    bit            outstanding = 0;
    int            delay = 0;
    logic [AW-1:0] out_addr = '0;
    int            out_epoch = 0;
    int            epoch = 0;
    int            n_grants = 0;
    int            n_pops = 0;
    logic [AW-1:0] last_grant = '0;
    logic [AW-1:0] last_pop_pc = '0;
    logic [AW-1:0] exp_addr = RESET_PC;

    // knobs (percent, redirect in permille)
    int p_gnt, p_rv, p_ready, p_spur, p_redir, min_delay, max_delay;
    bit force_redir = 0;
    logic [AW-1:0] force_pc = '0;

    // samples taken at the falling edge
    logic          s_req, s_valid;
    logic [AW-1:0] s_addr, s_pc;
    logic [CW-1:0] s_count;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'hC0DE_F00D;
    endfunction

    function automatic logic [AW-1:0] rand_pc();
        if ($urandom_range(3) == 0) return AW'('1) - AW'($urandom_range(1));
        return AW'($urandom());
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int dmin, input int dmax,
                             input int rd, input int sp);
        p_gnt = g; p_rv = rv; p_ready = rdy; min_delay = dmin; max_delay = dmax;
        p_redir = rd; p_spur = sp;
    endtask

    task automatic wait_neg();
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
        s_pc = inst_pc; s_count = count;
    endtask

    task automatic drive_edge();
        bit rv;
        if (outstanding) rv = !reset && delay == 0 && $urandom_range(99) < p_rv;
        else             rv = !reset && $urandom_range(99) < p_spur;
        imem_rvalid = rv;
        imem_rdata  = (rv && outstanding) ? mem_word(out_addr) : $urandom();
        imem_gnt    = !reset && $urandom_range(99) < p_gnt;
        inst_ready  = $urandom_range(99) < p_ready;
        redirect    = force_redir || $urandom_range(999) < p_redir;
        redirect_pc = force_redir ? force_pc : rand_pc();
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            outstanding = 0;
            epoch++;
        end else begin
            if (s_valid && inst_ready && !redirect) begin
                n_pops++;
                last_pop_pc = s_pc;
            end
            if (rv && outstanding) begin
                outstanding = 0;
                // Delivered only if no redirect since (and including) the grant.
                if (!redirect && out_epoch == epoch) exp_q.push_back({mem_word(out_addr), out_addr});
            end else if (s_req && imem_gnt) begin
                outstanding = 1;
                out_addr    = s_addr;
                out_epoch   = epoch;
                delay       = $urandom_range(max_delay, min_delay);
                n_grants++;
                last_grant  = s_addr;
            end else if (outstanding && delay != 0) begin
                delay--;
            end
            if (redirect) begin
                exp_q.delete();
                epoch++;
            end
        end
    endtask

    task automatic step();
        drive_edge();
        wait_neg();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic run_until_grant(input string name);
        int g0 = n_grants;
        for (int i = 0; i < 40 && n_grants == g0; i++) step();
        chk(name, n_grants != g0, 1);
    endtask

    task automatic fill_to(input int n, input string name);
        p_ready = 0;
        for (int i = 0; i < 60; i++) begin
            if (s_count == CW'(n) && outstanding) break;
            p_rv = (s_count < CW'(n)) ? 100 : 0;
            step();
        end
        chk(name, s_count == CW'(n) && outstanding, 1);
    endtask

    // Monitor: checks every cycle, pops the scoreboard on a live handshake.
    always @(negedge clk) begin
        ent_t e;
        #1;
        chk("count", count, exp_q.size());
        chk("inst_valid", inst_valid, exp_q.size() != 0);
        if (outstanding) chk("req_while_outstanding", imem_req, 0);
        if (reset) begin
            exp_addr = RESET_PC;
        end else begin
            if (imem_req && imem_gnt) begin
                chk("imem_addr", imem_addr, exp_addr);
                exp_addr = exp_addr + AW'(1);
            end
            if (redirect) begin
                exp_addr = redirect_pc;
            end else if (inst_valid && inst_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst", inst, e.word);
            end
        end
    end

    initial begin
        int cyc, next_pop, pops;
        reset = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        redirect = 0; redirect_pc = '0; inst_ready = 0;
        set_knobs(0, 0, 0, 0, 0, 0, 0);
        wait_neg();
        step();
        step();
        chk("rst_req", s_req, 0);
        chk("rst_valid", s_valid, 0);
        chk("rst_count", s_count, 0);

        // Streaming: rvalid arrives with one idle cycle after the grant.
        set_knobs(100, 100, 100, 1, 1, 0, 0);
        reset = 1'b0;
        step();
        chk("first_req", s_req, 1);
        chk("first_addr", s_addr, RESET_PC);
        cyc = 2; next_pop = 5; pops = 0;
        while (cyc < 30) begin
            step();
            cyc++;
            if (s_valid) begin
                chk("pop_cycle", cyc, next_pop);
                chk("pop_pc", s_pc, AW'(pops));
                next_pop += 3;
                pops++;
            end
        end
        chk("stream_pops", pops, 9);

        // Queue fills to DEPTH and stops requesting; one pop refills it.
        set_knobs(100, 100, 0, 0, 0, 0, 0);
        do_reset();
        n_grants = 0;
        repeat (20) step();
        chk("full_grants", n_grants, DEPTH);
        chk("full_count", s_count, DEPTH);
        chk("full_req", s_req, 0);
        p_ready = 100;
        step();
        p_ready = 0;
        repeat (10) step();
        chk("refill_grants", n_grants, DEPTH + 1);
        chk("refill_count", s_count, DEPTH);
        chk("refill_req", s_req, 0);

        // Redirect during WAIT: the late response is dropped.
        set_knobs(100, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 10 && !outstanding; i++) step();
        chk("reach_wait", outstanding, 1);
        force_redir = 1; force_pc = AW'('h40);
        step();
        force_redir = 0; p_rv = 100;
        step();
        chk("drop_count", s_count, 0);
        chk("drop_valid", s_valid, 0);
        p_ready = 100;
        run_until_grant("redir_grant_seen");
        chk("redir_addr", last_grant, AW'('h40));
        n_pops = 0;
        for (int i = 0; i < 20 && n_pops == 0; i++) step();
        chk("redir_first_pc", last_pop_pc, AW'('h40));

        // Redirect together with rvalid and a pop while two entries are queued.
        set_knobs(100, 100, 0, 0, 0, 0, 0);
        do_reset();
        fill_to(2, "reach_cnt2");
        p_rv = 100; p_ready = 100; force_redir = 1; force_pc = AW'('h123);
        step();
        force_redir = 0;
        chk("flush_count", s_count, 0);
        chk("flush_valid", s_valid, 0);
        repeat (20) step();

        // Fetch address wraps after the maximum word address.
        set_knobs(100, 100, 100, 0, 0, 0, 0);
        force_redir = 1; force_pc = AW'('1);
        step();
        force_redir = 0;
        run_until_grant("wrap_grant1_seen");
        chk("wrap_max_addr", last_grant, AW'('1));
        run_until_grant("wrap_grant2_seen");
        chk("wrap_zero_addr", last_grant, 0);

        // Reset in WAIT with three entries queued.
        set_knobs(100, 100, 0, 0, 0, 0, 0);
        do_reset();
        fill_to(3, "reach_cnt3");
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_wait_count", s_count, 0);
        chk("rst_wait_valid", s_valid, 0);
        chk("rst_wait_req", s_req, 0);
        run_until_grant("rst_refetch_seen");
        chk("rst_refetch_addr", last_grant, RESET_PC);

        // Random traffic.
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100),
                      0, $urandom_range(4), $urandom_range(80), $urandom_range(30));
            for (int i = 0; i < 200; i++) begin
                reset = ($urandom_range(499) == 0);
                step();
            end
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
